// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
// Two-requester round-robin front end for the 4-bit logic unit
// (op 00=AND, 01=OR, 10=XOR, 11=NOT a). One operation is in flight at a time.
// Operands and result are registered. Results return on a single
// valid/ready channel tagged with the requester ID. Saturating per-requester
// completion counters are kept for status readback.

module logic_unit_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic             rsp_id,
  output logic             busy,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // The shared combinational logic unit.
  function automatic logic [3:0] lu_eval(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input logic [1:0] op);
    logic [3:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      2'b11:   r = ~a;
      default: r = 4'h0;
    endcase
    return r;
  endfunction

  state_t           state_r;
  logic             last_id_r;
  logic [3:0]       a_r;
  logic [3:0]       b_r;
  logic [1:0]       op_r;
  logic             rsp_valid_r;
  logic [3:0]       rsp_result_r;
  logic             rsp_id_r;
  logic             busy_r;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  logic             grant_id_s;
  logic             grant_valid_s;
  logic             idle_s;
  logic             req_hs_s;
  logic             rsp_hs_s;
  logic [3:0]       sel_a_s;
  logic [3:0]       sel_b_s;
  logic [1:0]       sel_op_s;

  // Round-robin pick: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant_id_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id_s = ~last_id_r;
    end else if (req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
  end

  // Operand mux follows the grant so only the winner's inputs are captured.
  always_comb begin
    sel_a_s  = req0_a;
    sel_b_s  = req0_b;
    sel_op_s = req0_op;
    if (grant_id_s) begin
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
      sel_op_s = req1_op;
    end else begin
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
      sel_op_s = req0_op;
    end
  end

  assign grant_valid_s = req0_valid | req1_valid;
  assign idle_s        = (state_r == IDLE);
  assign req_hs_s      = idle_s & grant_valid_s;
  assign rsp_hs_s      = rsp_valid_r & rsp_ready;

  assign req0_ready = idle_s & grant_valid_s & ~grant_id_s;
  assign req1_ready = idle_s & grant_valid_s & grant_id_s;

  // Control FSM: accept in IDLE, evaluate in EXEC, hold the response in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_id_r    <= 1'b1;
      a_r          <= 4'h0;
      b_r          <= 4'h0;
      op_r         <= 2'b00;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= 4'h0;
      rsp_id_r     <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_hs_s) begin
            a_r       <= sel_a_s;
            b_r       <= sel_b_s;
            op_r      <= sel_op_s;
            last_id_r <= grant_id_s;
            state_r   <= EXEC;
            busy_r    <= 1'b1;
          end else begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
          end
        end
        EXEC: begin
          rsp_result_r <= lu_eval(a_r, b_r, op_r);
          rsp_id_r     <= last_id_r;
          rsp_valid_r  <= 1'b1;
          state_r      <= RESP;
          busy_r       <= 1'b1;
        end
        RESP: begin
          if (rsp_hs_s) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
            busy_r      <= 1'b0;
          end else begin
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
            busy_r      <= 1'b1;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Saturating completion counters; a clear overrides a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_r <= '0;
      cnt1_r <= '0;
    end else if (cnt_clr) begin
      cnt0_r <= '0;
      cnt1_r <= '0;
    end else if (rsp_hs_s) begin
      if (rsp_id_r == 1'b0) begin
        if (cnt0_r != CNT_MAX) begin
          cnt0_r <= cnt0_r + CNT_W'(1);
        end else begin
          cnt0_r <= cnt0_r;
        end
      end else begin
        if (cnt1_r != CNT_MAX) begin
          cnt1_r <= cnt1_r + CNT_W'(1);
        end else begin
          cnt1_r <= cnt1_r;
        end
      end
    end else begin
      cnt0_r <= cnt0_r;
      cnt1_r <= cnt1_r;
    end
  end

  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = rsp_result_r;
  assign rsp_id     = rsp_id_r;
  assign busy       = busy_r;
  assign cnt0       = cnt0_r;
  assign cnt1       = cnt1_r;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter
// Scenario tasks for the round-robin logic unit front end, with a
// truth-table reference for the logic unit and a transaction-level
// model for randomized traffic.

module tb_logic_unit_arbiter;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [3:0]       req0_a, req0_b, req1_a, req1_b;
  logic [1:0]       req0_op, req1_op;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [3:0]       rsp_result;
  logic             busy, cnt_clr;
  logic [CNT_W-1:0] cnt0, cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  logic_unit_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_id(rsp_id),
    .busy(busy), .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  // Reference: each result bit looked up in a 2-input truth table indexed by {a,b}.
  function automatic logic [3:0] ref_result(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] op);
    logic [3:0] tt;
    logic [3:0] r;
    case (op)
      2'd0:    tt = 4'b1000;
      2'd1:    tt = 4'b1110;
      2'd2:    tt = 4'b0110;
      default: tt = 4'b0011;
    endcase
    for (int i = 0; i < 4; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 4'h0; req0_b = 4'h0; req0_op = 2'd0;
    req1_a = 4'h0; req1_b = 4'h0; req1_op = 2'd0;
    rsp_ready = 1'b0; cnt_clr = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_id, busy, req0_ready, req1_ready} !== 9'b0 ||
        cnt0 !== 2'd0 || cnt1 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got valid=%b res=%h id=%b busy=%b rdy=%b%b cnt=%0d/%0d, want all zero",
               rsp_valid, rsp_result, rsp_id, busy, req0_ready, req1_ready, cnt0, cnt1);
    end
    step();
    req0_valid = 1'b1; req0_a = 4'hF; req0_b = 4'hF; req0_op = 2'd0; rsp_ready = 1'b0;
    step();
    req0_valid = 1'b0;
    step();
    #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_pre_resp: got valid=%b res=%h, want 1 f", rsp_valid, rsp_result);
    end
    step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_result, rsp_id, busy, req0_ready, req1_ready} !== 9'b0 ||
        cnt0 !== 2'd0 || cnt1 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_midrun: got valid=%b res=%h id=%b busy=%b rdy=%b%b cnt=%0d/%0d, want all zero",
               rsp_valid, rsp_result, rsp_id, busy, req0_ready, req1_ready, cnt0, cnt1);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    logic [3:0] exp_tab [4];
    logic [1:0] exp_cnt;
    exp_tab[0] = 4'h8; exp_tab[1] = 4'hE; exp_tab[2] = 4'h6; exp_tab[3] = 4'h3;
    exp_cnt = 2'd0;
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1; req0_a = 4'hC; req0_b = 4'hA; req0_op = 2'(k);
      req1_valid = 1'b0; rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL single_accept op%0d: got rdy=%b%b busy=%b, want rdy0=1 rdy1=0 busy=0",
                 k, req0_ready, req1_ready, busy);
      end
      step();
      req0_valid = 1'b0; req0_a = 4'(($urandom)); req0_b = 4'(($urandom));
      #1;
      n_checks++;
      if (busy !== 1'b1 || rsp_valid !== 1'b0 || req0_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL single_exec op%0d: got busy=%b valid=%b rdy0=%b, want 1 0 0",
                 k, busy, rsp_valid, req0_ready);
      end
      step();
      #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== exp_tab[k] || rsp_id !== 1'b0) begin
        n_fail++;
        $display("FAIL single_resp op%0d: got valid=%b res=%h id=%b, want 1 %h 0",
                 k, rsp_valid, rsp_result, rsp_id, exp_tab[k]);
      end
      step();
      exp_cnt = (exp_cnt == 2'd3) ? exp_cnt : exp_cnt + 2'd1;
      #1;
      n_checks++;
      if (cnt0 !== exp_cnt || busy !== 1'b0 || rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_count op%0d: got cnt0=%0d busy=%b valid=%b, want %0d 0 0",
                 k, cnt0, busy, rsp_valid, exp_cnt);
      end
    end
  endtask

  task automatic test_contention();
    logic       exp_id;
    logic [3:0] exp_res;
    do_reset();
    req1_valid = 1'b1; req1_a = 4'h1; req1_b = 4'h2; req1_op = 2'd1;
    req0_valid = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 2'($urandom);
      exp_id  = (k % 2 == 1);
      exp_res = exp_id ? ref_result(4'h1, 4'h2, 2'd1) : ref_result(req0_a, req0_b, req0_op);
      #1;
      n_checks++;
      if (req0_ready !== ~exp_id || req1_ready !== exp_id) begin
        n_fail++;
        $display("FAIL contention_grant #%0d: got rdy=%b%b, want rdy0=%b rdy1=%b",
                 k, req0_ready, req1_ready, ~exp_id, exp_id);
      end
      step();
      #1;
      n_checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL contention_noready #%0d: got rdy=%b%b, want 00", k, req0_ready, req1_ready);
      end
      step();
      #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_result !== exp_res) begin
        n_fail++;
        $display("FAIL contention_resp #%0d: got valid=%b id=%b res=%h, want 1 %b %h",
                 k, rsp_valid, rsp_id, rsp_result, exp_id, exp_res);
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    req1_valid = 1'b1; req1_a = 4'h5; req1_b = 4'h3; req1_op = 2'd2; rsp_ready = 1'b0;
    #1;
    n_checks++;
    if (req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept: got rdy1=%b, want 1", req1_ready);
    end
    step();
    req1_valid = 1'b0;
    step();
    for (int h = 0; h < 5; h++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 4'h6 || rsp_id !== 1'b1 || busy !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: got valid=%b res=%h id=%b busy=%b rdy=%b%b, want 1 6 1 1 00",
                 h, rsp_valid, rsp_result, rsp_id, busy, req0_ready, req1_ready);
      end
      step();
    end
    rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%b, want 1", rsp_valid);
    end
    step();
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_done: got valid=%b busy=%b, want 0 0", rsp_valid, busy);
    end
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_counters();
    logic [1:0] exp_cnt;
    do_reset();
    exp_cnt = 2'd0;
    rsp_ready = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      req1_valid = 1'b1; req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 2'($urandom);
      step();
      req1_valid = 1'b0;
      step();
      if (n == 6) cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      if (n == 6) exp_cnt = 2'd0;
      else exp_cnt = (exp_cnt == 2'd3) ? exp_cnt : exp_cnt + 2'd1;
      #1;
      n_checks++;
      if (cnt1 !== exp_cnt || cnt0 !== 2'd0) begin
        n_fail++;
        $display("FAIL counter_sat n=%0d: got cnt1=%0d cnt0=%0d, want %0d 0", n, cnt1, cnt0, exp_cnt);
      end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    req0_valid = 1'b1; req0_a = 4'h9; req0_b = 4'h6; req0_op = 2'd1; rsp_ready = 1'b1;
    step();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || cnt1 !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_clear: got busy=%b valid=%b cnt1=%0d, want 0 0 0", busy, rsp_valid, cnt1);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_norsp cyc%0d: got valid=%b, want 0", c, rsp_valid);
      end
      step();
    end
    req0_valid = 1'b1; req0_a = 4'h3; req0_b = 4'h5; req0_op = 2'd2;
    req1_valid = 1'b1; req1_a = 4'h0; req1_b = 4'h0; req1_op = 2'd0;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_priority: got rdy=%b%b, want rdy0=1 rdy1=0", req0_ready, req1_ready);
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    #1;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 4'h6 || rsp_id !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_resp: got valid=%b res=%h id=%b, want 1 6 0", rsp_valid, rsp_result, rsp_id);
    end
    step();
    #1;
    n_checks++;
    if (cnt0 !== 2'd1) begin
      n_fail++;
      $display("FAIL rstmid_cnt: got cnt0=%0d, want 1", cnt0);
    end
    rsp_ready = 1'b0;
  endtask

  // Randomized traffic against a transaction model: one op in flight, result
  // visible two cycles after acceptance, held until taken.
  task automatic test_random();
    logic       m_last, pend, pend_id, g, any, hs;
    logic [3:0] pend_res;
    logic [1:0] mc0, mc1;
    int         lag;
    do_reset();
    m_last = 1'b1; pend = 1'b0; pend_id = 1'b0; pend_res = 4'h0;
    mc0 = 2'd0; mc1 = 2'd0; lag = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
      req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 2'($urandom);
      req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 15) == 0);
      #1;
      any = !pend && (req0_valid || req1_valid);
      g   = (req0_valid && req1_valid) ? !m_last : req1_valid;
      n_checks++;
      if (req0_ready !== (any && !g) || req1_ready !== (any && g) || busy !== pend ||
          rsp_valid !== (pend && lag == 0) || cnt0 !== mc0 || cnt1 !== mc1) begin
        n_fail++;
        $display("FAIL random_ctrl cyc%0d: got rdy=%b%b busy=%b valid=%b cnt=%0d/%0d, want rdy=%b%b busy=%b valid=%b cnt=%0d/%0d",
                 cyc, req0_ready, req1_ready, busy, rsp_valid, cnt0, cnt1,
                 any && !g, any && g, pend, pend && lag == 0, mc0, mc1);
      end
      hs = 1'b0;
      if (!pend) begin
        if (any) begin
          pend = 1'b1; pend_id = g; m_last = g; lag = 1;
          pend_res = g ? ref_result(req1_a, req1_b, req1_op) : ref_result(req0_a, req0_b, req0_op);
        end
      end else if (lag > 0) begin
        lag--;
      end else begin
        n_checks++;
        if (rsp_result !== pend_res || rsp_id !== pend_id) begin
          n_fail++;
          $display("FAIL random_resp cyc%0d: got res=%h id=%b, want %h %b",
                   cyc, rsp_result, rsp_id, pend_res, pend_id);
        end
        if (rsp_ready) begin
          pend = 1'b0; hs = 1'b1;
        end
      end
      if (cnt_clr) begin
        mc0 = 2'd0; mc1 = 2'd0;
      end else if (hs) begin
        if (pend_id) mc1 = (mc1 == 2'd3) ? mc1 : mc1 + 2'd1;
        else         mc0 = (mc0 == 2'd3) ? mc0 : mc0 + 2'd1;
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_counters();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
